// File: rtl/uart_msg_scheduler.sv
// uart_msg_scheduler: round-robin framer sharing one UART byte transmitter among three event sources
// Ports: clk_50/rst system clock and synchronous active-high reset;
//        req_stb/req_data0..2 per-source request strobes and payloads;
//        tx_data/tx_valid/tx_ready byte handshake toward the UART;
//        busy (any non-IDLE state), pending (per-source buffered request), drop_cnt (saturating drops).
module uart_msg_scheduler #(
    parameter logic [7:0] HDR0 = 8'h43,
    parameter logic [7:0] HDR1 = 8'h4E,
    parameter logic [7:0] HDR2 = 8'h45,
    parameter logic [7:0] TERM = 8'h23,
    parameter int         GAP  = 50
) (
    input  logic       clk_50,
    input  logic       rst,
    input  logic [2:0] req_stb,
    input  logic [7:0] req_data0,
    input  logic [7:0] req_data1,
    input  logic [7:0] req_data2,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    output logic       busy,
    output logic [2:0] pending,
    output logic [7:0] drop_cnt
);
    typedef enum logic [2:0] {IDLE, HDR, PAY, TRM, WAIT} state_t;
    localparam logic [15:0] GAP_M1 = GAP == 0 ? 16'd0 : 16'(GAP - 1);
    state_t      state, state_n;
    logic [7:0]  req_data [3];
    logic [7:0]  pay_buf [3];
    logic [7:0]  msg_pay, msg_pay_n, tx_data_n, hdr_sel, pay_sel;
    logic [15:0] gap_cnt, gap_cnt_n;
    logic [1:0]  last, c1, c2, sel;
    logic [2:0]  gclr, drops, pending_n;
    logic [8:0]  drop_sum;
    logic        grant, accept, tx_valid_n;
    assign busy = state != IDLE;
    always_comb begin
        req_data[0] = req_data0;
        req_data[1] = req_data1;
        req_data[2] = req_data2;
        accept = tx_valid & tx_ready;
        grant = state == IDLE && |pending;
        // search order last+1, last+2, last (mod 3)
        c1 = last == 2'd2 ? 2'd0 : last + 2'd1;
        c2 = last == 2'd0 ? 2'd2 : last - 2'd1;
        sel = pending[c1] ? c1 : pending[c2] ? c2 : last;
        hdr_sel = sel == 2'd0 ? HDR0 : sel == 2'd1 ? HDR1 : HDR2;
        pay_sel = sel == 2'd0 ? pay_buf[0] : sel == 2'd1 ? pay_buf[1] : pay_buf[2];
        gclr = grant ? 3'b001 << sel : 3'b000;
        // a strobe landing on its own grant clear refills the buffer instead of dropping
        drops = req_stb & pending & ~gclr;
        pending_n = (pending & ~gclr) | req_stb;
        drop_sum = {1'b0, drop_cnt} + 9'(drops[0]) + 9'(drops[1]) + 9'(drops[2]);
        state_n = state;
        tx_data_n = tx_data;
        msg_pay_n = msg_pay;
        gap_cnt_n = gap_cnt;
        case (state)
            IDLE: if (grant) begin
                state_n = HDR;
                tx_data_n = hdr_sel;
                msg_pay_n = pay_sel;
            end
            HDR: if (accept) begin
                state_n = PAY;
                tx_data_n = msg_pay;
            end
            PAY: if (accept) begin
                state_n = TRM;
                tx_data_n = TERM;
            end
            TRM: if (accept) begin
                state_n = GAP == 0 ? IDLE : WAIT;
                gap_cnt_n = GAP_M1;
            end
            WAIT: if (gap_cnt == 16'd0) state_n = IDLE;
                  else gap_cnt_n = gap_cnt - 16'd1;
            default: state_n = IDLE;
        endcase
        tx_valid_n = state_n == HDR || state_n == PAY || state_n == TRM;
    end
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state <= IDLE;
            tx_valid <= 1'b0;
            tx_data <= 8'h00;
            msg_pay <= 8'h00;
            gap_cnt <= 16'd0;
            pending <= 3'b000;
            drop_cnt <= 8'd0;
            last <= 2'd2;
        end else begin
            state <= state_n;
            tx_valid <= tx_valid_n;
            tx_data <= tx_data_n;
            msg_pay <= msg_pay_n;
            gap_cnt <= gap_cnt_n;
            pending <= pending_n;
            drop_cnt <= drop_sum > 9'd255 ? 8'hFF : drop_sum[7:0];
            if (grant) last <= sel;
        end
    end
    always_ff @(posedge clk_50) begin
        for (int i = 0; i < 3; i++)
            if (!rst && req_stb[i] && (!pending[i] || gclr[i])) pay_buf[i] <= req_data[i];
    end
endmodule

// File: tb/tb_uart_msg_scheduler.sv
// tb_uart_msg_scheduler: table, directed and randomized checks of two schedulers (GAP=4 and GAP=0)
module tb_uart_msg_scheduler;
    logic       clk_50 = 1'b0, rst = 1'b1, tx_ready = 1'b1;
    logic [2:0] req_stb = 3'b000;
    logic [7:0] req_data0 = 8'h00, req_data1 = 8'h00, req_data2 = 8'h00;
    logic [7:0] tx_data_a, tx_data_b, drop_a, drop_b;
    logic       tx_valid_a, tx_valid_b, busy_a, busy_b;
    logic [2:0] pending_a, pending_b;
    int         checks = 0, errors = 0, cyc = 0;
    bit         chk_en = 1'b0;

    always #10 clk_50 = ~clk_50;
    always @(posedge clk_50) cyc <= cyc + 1;

    uart_msg_scheduler #(.GAP(4)) dut_a (
        .clk_50(clk_50), .rst(rst), .req_stb(req_stb),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .tx_data(tx_data_a), .tx_valid(tx_valid_a), .tx_ready(tx_ready),
        .busy(busy_a), .pending(pending_a), .drop_cnt(drop_a));
    uart_msg_scheduler #(.GAP(0)) dut_b (
        .clk_50(clk_50), .rst(rst), .req_stb(req_stb),
        .req_data0(req_data0), .req_data1(req_data1), .req_data2(req_data2),
        .tx_data(tx_data_b), .tx_valid(tx_valid_b), .tx_ready(tx_ready),
        .busy(busy_b), .pending(pending_b), .drop_cnt(drop_b));

    typedef struct {
        int         src;
        logic [7:0] data;
        logic [7:0] hdr;
    } vec_t;
    vec_t vt[5];

    logic [7:0] acc_a[$], acc_b[$], exp_q[$];
    int         cyc_a[$], cyc_b[$];

    // transaction-level reference: each instance holds a 3-byte message being sent,
    // remaining idle-gap cycles, and per-source one-entry buffers
    int         mpos[2], mgap[2], mlast[2], mdrop[2];
    logic [7:0] mmsg[2][3], mdat[2][3];
    logic [2:0] mpend[2];
    bit         hold_a, hold_b;
    logic [7:0] hold_da, hold_db;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] rd(int i);
        return i == 0 ? req_data0 : i == 1 ? req_data1 : req_data2;
    endfunction

    task automatic model_reset(int k);
        mpos[k] = 3; mgap[k] = 0; mlast[k] = 2; mdrop[k] = 0; mpend[k] = 3'b000;
    endtask

    task automatic model_check(int k, logic [7:0] d, logic v, logic b, logic [2:0] p, logic [7:0] dc);
        check(k == 0 ? "model busy a" : "model busy b", b, mpos[k] < 3 || mgap[k] > 0);
        check(k == 0 ? "model valid a" : "model valid b", v, mpos[k] < 3);
        if (mpos[k] < 3) check(k == 0 ? "model data a" : "model data b", d, mmsg[k][mpos[k]]);
        check(k == 0 ? "model pending a" : "model pending b", p, mpend[k]);
        check(k == 0 ? "model drop a" : "model drop b", dc, mdrop[k]);
    endtask

    task automatic model_step(int k);
        int s;
        if (rst) begin
            model_reset(k);
            return;
        end
        if (mpos[k] < 3) begin
            if (tx_ready) begin
                mpos[k]++;
                if (mpos[k] == 3) mgap[k] = k == 0 ? 4 : 0;
            end
        end else if (mgap[k] > 0) mgap[k]--;
        else if (mpend[k] != 3'b000) begin
            for (int j = 1; j <= 3; j++) begin
                s = (mlast[k] + j) % 3;
                if (mpend[k][s]) break;
            end
            mmsg[k][0] = s == 0 ? 8'h43 : s == 1 ? 8'h4E : 8'h45;
            mmsg[k][1] = mdat[k][s];
            mmsg[k][2] = 8'h23;
            mpos[k] = 0;
            mpend[k][s] = 1'b0;
            mlast[k] = s;
        end
        for (int i = 0; i < 3; i++)
            if (req_stb[i]) begin
                if (!mpend[k][i]) begin
                    mpend[k][i] = 1'b1;
                    mdat[k][i] = rd(i);
                end else if (mdrop[k] < 255) mdrop[k]++;
            end
    endtask

    always @(negedge clk_50) begin
        if (chk_en) begin
            model_check(0, tx_data_a, tx_valid_a, busy_a, pending_a, drop_a);
            model_check(1, tx_data_b, tx_valid_b, busy_b, pending_b, drop_b);
            if (hold_a) check("hold a", {tx_valid_a, tx_data_a}, {1'b1, hold_da});
            if (hold_b) check("hold b", {tx_valid_b, tx_data_b}, {1'b1, hold_db});
        end
        hold_a = tx_valid_a && !tx_ready && !rst;
        hold_b = tx_valid_b && !tx_ready && !rst;
        hold_da = tx_data_a;
        hold_db = tx_data_b;
        if (tx_valid_a && tx_ready) begin acc_a.push_back(tx_data_a); cyc_a.push_back(cyc); end
        if (tx_valid_b && tx_ready) begin acc_b.push_back(tx_data_b); cyc_b.push_back(cyc); end
        model_step(0);
        model_step(1);
    end

    task automatic tick;
        @(posedge clk_50);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick;
        rst = 1'b0;
    endtask

    task automatic clear_logs;
        acc_a.delete(); acc_b.delete(); cyc_a.delete(); cyc_b.delete();
    endtask

    task automatic wait_idle;
        int w = 0;
        while ((busy_a || busy_b || pending_a != 3'b000 || pending_b != 3'b000) && w < 300) begin
            tick;
            w++;
        end
        check("idle reached", w < 300, 1);
    endtask

    task automatic wait_bytes(int n);
        int w = 0;
        while ((acc_a.size() < n || acc_b.size() < n) && w < 500) begin
            tick;
            w++;
        end
        check("bytes arrived", acc_a.size() >= n && acc_b.size() >= n, 1);
    endtask

    task automatic check_seq(string name);
        check({name, " len a"}, acc_a.size(), exp_q.size());
        check({name, " len b"}, acc_b.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i < acc_a.size()) check({name, " byte a"}, acc_a[i], exp_q[i]);
            if (i < acc_b.size()) check({name, " byte b"}, acc_b[i], exp_q[i]);
        end
    endtask

    initial begin
        int t;
        vt = '{'{0, 8'h52, 8'h43}, '{1, 8'hA5, 8'h4E}, '{2, 8'h00, 8'h45},
               '{0, 8'hFF, 8'h43}, '{2, 8'h5A, 8'h45}};
        repeat (2) tick;
        rst = 1'b0;
        chk_en = 1'b1;
        @(negedge clk_50);
        check("reset valid", {tx_valid_a, tx_valid_b}, 2'b00);
        check("reset data", {tx_data_a, tx_data_b}, 16'h0000);
        check("reset busy", {busy_a, busy_b}, 2'b00);
        check("reset pending", {pending_a, pending_b}, 6'b0);
        check("reset drop", {drop_a, drop_b}, 16'h0000);

        foreach (vt[v]) begin
            wait_idle;
            clear_logs;
            {req_data0, req_data1, req_data2} = {3{vt[v].data}};
            req_stb = 3'b001 << vt[v].src;
            t = cyc;
            tick;
            req_stb = 3'b000;
            wait_bytes(3);
            exp_q = {vt[v].hdr, vt[v].data, 8'h23};
            check_seq("vector");
            if (cyc_a.size() >= 3) begin
                check("vector hdr cycle", cyc_a[0] - t, 2);
                check("vector term cycle", cyc_a[2] - t, 4);
            end
        end

        wait_idle;
        req_data0 = 8'h52;
        req_stb = 3'b001;
        t = cyc;
        tick;
        req_stb = 3'b000;
        while (cyc < t + 4) tick;
        @(negedge clk_50);
        check("gap0 busy at t+4", busy_b, 1);
        tick;
        @(negedge clk_50);
        check("gap0 busy at t+5", busy_b, 0);
        while (cyc < t + 8) tick;
        @(negedge clk_50);
        check("busy at t+8", busy_a, 1);
        tick;
        @(negedge clk_50);
        check("busy at t+9", busy_a, 0);
        check("pending at t+9", pending_a, 3'b000);

        do_reset;
        clear_logs;
        {req_data0, req_data1, req_data2} = {8'h11, 8'h22, 8'h33};
        req_stb = 3'b111;
        tick;
        req_stb = 3'b000;
        wait_bytes(9);
        exp_q = {8'h43, 8'h11, 8'h23, 8'h4E, 8'h22, 8'h23, 8'h45, 8'h33, 8'h23};
        check_seq("simultaneous");
        if (cyc_a.size() >= 9 && cyc_b.size() >= 9) begin
            check("gap4 spacing 1", cyc_a[3] - cyc_a[2], 6);
            check("gap4 spacing 2", cyc_a[6] - cyc_a[5], 6);
            check("gap0 spacing", cyc_b[3] - cyc_b[2], 2);
        end

        wait_idle;
        clear_logs;
        req_data1 = 8'hC3;
        req_stb = 3'b010;
        for (int i = 0; i < 30; i++) begin
            tx_ready = ((i / 3) % 2) == 1;
            tick;
            req_stb = 3'b000;
        end
        tx_ready = 1'b1;
        wait_bytes(3);
        exp_q = {8'h4E, 8'hC3, 8'h23};
        check_seq("backpressure");

        do_reset;
        clear_logs;
        req_data0 = 8'h5A;
        req_stb = 3'b001;
        tick;
        req_stb = 3'b010;
        for (int i = 0; i < 4; i++) begin
            req_data1 = 8'h61 + 8'(i);
            tick;
        end
        req_stb = 3'b000;
        wait_bytes(6);
        exp_q = {8'h43, 8'h5A, 8'h23, 8'h4E, 8'h61, 8'h23};
        check_seq("overflow");
        check("overflow drop a", drop_a, 3);
        check("overflow drop b", drop_b, 3);

        do_reset;
        tx_ready = 1'b0;
        req_stb = 3'b111;
        repeat (110) begin
            {req_data0, req_data1, req_data2} = 24'($urandom);
            tick;
        end
        req_stb = 3'b000;
        @(negedge clk_50);
        check("saturate drop a", drop_a, 8'hFF);
        check("saturate drop b", drop_b, 8'hFF);
        tx_ready = 1'b1;

        do_reset;
        clear_logs;
        req_data2 = 8'h77;
        req_stb = 3'b100;
        tick;
        req_data2 = 8'h99;
        tick;
        req_stb = 3'b000;
        @(negedge clk_50);
        check("collision pending a", pending_a, 3'b100);
        check("collision pending b", pending_b, 3'b100);
        wait_bytes(6);
        exp_q = {8'h45, 8'h77, 8'h23, 8'h45, 8'h99, 8'h23};
        check_seq("collision");
        check("collision drop", {drop_a, drop_b}, 16'h0000);

        do_reset;
        clear_logs;
        req_data1 = 8'h70;
        req_stb = 3'b010;
        tick;
        req_stb = 3'b000;
        tick;
        tick;
        tx_ready = 1'b0;
        {req_data0, req_data2} = {8'h01, 8'h02};
        req_stb = 3'b101;
        tick;
        req_stb = 3'b000;
        @(negedge clk_50);
        check("mid payload a", {tx_valid_a, tx_data_a}, {1'b1, 8'h70});
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        @(negedge clk_50);
        check("mid reset valid", {tx_valid_a, tx_valid_b}, 2'b00);
        check("mid reset busy", {busy_a, busy_b}, 2'b00);
        check("mid reset pending", {pending_a, pending_b}, 6'b0);
        clear_logs;
        tx_ready = 1'b1;
        {req_data0, req_data1, req_data2} = {8'hA0, 8'hB0, 8'hC0};
        req_stb = 3'b111;
        tick;
        req_stb = 3'b000;
        wait_bytes(3);
        exp_q = {8'h43, 8'hA0, 8'h23};
        for (int i = 0; i < 3; i++) begin
            check("after reset a", acc_a[i], exp_q[i]);
            check("after reset b", acc_b[i], exp_q[i]);
        end

        for (int i = 0; i < 3000; i++) begin
            req_stb = ($urandom % 4 == 0) ? 3'($urandom) : 3'b000;
            {req_data0, req_data1, req_data2} = 24'($urandom);
            tx_ready = $urandom % 4 != 0;
            rst = $urandom % 400 == 0;
            tick;
        end
        rst = 1'b0;
        req_stb = 3'b000;
        tx_ready = 1'b1;
        wait_idle;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
